// File: rtl/ram_sync_param.sv
// Simple-dual-port RAM with registered read (latency 1 or 2), selectable
// read-during-write behaviour, out-of-range flagging and a post-reset clear sequencer.
module ram_sync_param #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 11,
    parameter int DEPTH          = 2048,
    parameter int RD_LATENCY     = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              busy,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr_r,
    output logic [DATA_W-1:0] data_r,
    output logic              valid_r,
    output logic              err_r,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [DATA_W-1:0] data_w
);
    localparam int                MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LIMIT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("RD_LATENCY must be 1 or 2");
        end
        if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("DEPTH must lie in 1 .. 2**ADDR_W");
        end
    endgenerate

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              clear_we;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q;

    logic              rd_in_range, wr_in_range;
    logic              rd_accept, wr_accept, bypass_hit;
    logic [MEM_AW-1:0] rd_idx;

    // Stage-1 side information travelling alongside the block RAM output.
    logic              s1_valid_reg, s1_err_reg, s1_zero_reg, s1_byp_reg;
    logic [DATA_W-1:0] s1_wdata_reg;
    logic [DATA_W-1:0] s1_data;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        clear_we   = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                clear_we = ~reset;
                ptr_next = ptr_reg + ADDR_W'(1);
                if (ptr_reg == LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign busy        = (state_reg == ST_CLEAR);
    assign rd_in_range = ({1'b0, addr_r} < LIMIT);
    assign wr_in_range = ({1'b0, addr_w} < LIMIT);
    assign rd_accept   = re & ~busy & ~reset;
    assign wr_accept   = we & ~busy & ~reset & wr_in_range;
    assign rd_idx      = rd_in_range ? addr_r[MEM_AW-1:0] : '0;
    assign bypass_hit  = (BYPASS != 0) && wr_accept && rd_in_range && (addr_r == addr_w);

    // No reset on the array or its output register so the tools can map it to block RAM.
    always_ff @(posedge clock) begin
        if (clear_we) begin
            mem[ptr_reg[MEM_AW-1:0]] <= '0;
        end else if (wr_accept) begin
            mem[addr_w[MEM_AW-1:0]] <= data_w;
        end
        if (rd_accept) begin
            mem_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_zero_reg  <= 1'b1;
            s1_byp_reg   <= 1'b0;
            s1_wdata_reg <= '0;
        end else begin
            s1_valid_reg <= rd_accept;
            s1_err_reg   <= rd_accept & ~rd_in_range;
            if (rd_accept) begin
                s1_zero_reg  <= ~rd_in_range;
                s1_byp_reg   <= bypass_hit;
                s1_wdata_reg <= data_w;
            end
        end
    end

    // Zero-forcing also covers the post-reset value, since mem_q itself is never reset.
    assign s1_data = s1_zero_reg ? '0 : (s1_byp_reg ? s1_wdata_reg : mem_q);

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] data2_reg;
            logic              valid2_reg, err2_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    data2_reg  <= '0;
                    valid2_reg <= 1'b0;
                    err2_reg   <= 1'b0;
                end else begin
                    valid2_reg <= s1_valid_reg;
                    err2_reg   <= s1_err_reg;
                    if (s1_valid_reg) begin
                        data2_reg <= s1_data;
                    end
                end
            end

            assign data_r  = data2_reg;
            assign valid_r = valid2_reg;
            assign err_r   = err2_reg;
        end else begin : g_lat1
            assign data_r  = s1_data;
            assign valid_r = s1_valid_reg;
            assign err_r   = s1_err_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sync_param.sv
// Bench for ram_sync_param: two instances (latency 1 + bypass, latency 2 + old-data)
// share one stimulus stream and are checked against an array-based reference model.
module tb_ram_sync_param;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEP_A = 40;
    localparam int DEP_B = 64;

    logic          clock  = 1'b0;
    logic          reset  = 1'b1;
    logic          re     = 1'b0;
    logic          we     = 1'b0;
    logic [AW-1:0] addr_r = '0;
    logic [AW-1:0] addr_w = '0;
    logic [DW-1:0] data_w = '0;

    logic          busy_a, valid_a, err_a;
    logic [DW-1:0] data_a;
    logic          busy_b, valid_b, err_b;
    logic [DW-1:0] data_b;

    always #5 clock = ~clock;

    ram_sync_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP_A),
        .RD_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clock(clock), .reset(reset), .busy(busy_a),
        .re(re), .addr_r(addr_r), .data_r(data_a), .valid_r(valid_a), .err_r(err_a),
        .we(we), .addr_w(addr_w), .data_w(data_w)
    );

    ram_sync_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP_B),
        .RD_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clock(clock), .reset(reset), .busy(busy_b),
        .re(re), .addr_r(addr_r), .data_r(data_b), .valid_r(valid_b), .err_r(err_b),
        .we(we), .addr_w(addr_w), .data_w(data_w)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int m_dep[2] = '{DEP_A, DEP_B};
    int m_lat[2] = '{1, 2};
    int m_byp[2] = '{1, 0};
    int m_mem[2][64];
    int m_busy[2];
    // Read results scheduled by the edge number at which they must appear.
    bit sch_v[2][4];
    int sch_d[2][4];
    bit sch_e[2][4];
    int e_data[2];
    bit e_valid[2];
    bit e_err[2];

    typedef struct {
        int re; int ar; int we; int aw; int dw;
        int va; int da; int ea;
        int vb; int db; int eb;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input int k);
        int slot;
        if (reset) begin
            m_busy[k] = m_dep[k];
            for (int s = 0; s < 4; s++) sch_v[k][s] = 1'b0;
            e_data[k]  = 0;
            e_valid[k] = 1'b0;
            e_err[k]   = 1'b0;
            return;
        end
        if (m_busy[k] > 0) begin
            m_mem[k][m_dep[k] - m_busy[k]] = 0;
            m_busy[k]--;
        end else begin
            if (re) begin
                slot = (cyc + m_lat[k] - 1) % 4;
                sch_v[k][slot] = 1'b1;
                if (int'(addr_r) >= m_dep[k]) begin
                    sch_d[k][slot] = 0;
                    sch_e[k][slot] = 1'b1;
                end else begin
                    sch_e[k][slot] = 1'b0;
                    if (m_byp[k] != 0 && we && addr_w == addr_r)
                        sch_d[k][slot] = int'(data_w);
                    else
                        sch_d[k][slot] = m_mem[k][addr_r];
                end
            end
            if (we && int'(addr_w) < m_dep[k]) m_mem[k][addr_w] = int'(data_w);
        end
        slot = cyc % 4;
        if (sch_v[k][slot]) begin
            e_valid[k] = 1'b1;
            e_data[k]  = sch_d[k][slot];
            e_err[k]   = sch_e[k][slot];
            sch_v[k][slot] = 1'b0;
        end else begin
            e_valid[k] = 1'b0;
            e_err[k]   = 1'b0;
        end
    endtask

    task automatic step(input bit rst, input bit r, input int ar, input bit w, input int aw, input int dw);
        reset  = rst;
        re     = r;
        addr_r = AW'(ar);
        we     = w;
        addr_w = AW'(aw);
        data_w = DW'(dw);
        @(posedge clock);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        chk("busy_a",  32'(busy_a),  32'(m_busy[0] > 0));
        chk("valid_a", 32'(valid_a), 32'(e_valid[0]));
        chk("err_a",   32'(err_a),   32'(e_err[0]));
        chk("data_a",  32'(data_a),  32'(e_data[0]));
        chk("busy_b",  32'(busy_b),  32'(m_busy[1] > 0));
        chk("valid_b", 32'(valid_b), 32'(e_valid[1]));
        chk("err_b",   32'(err_b),   32'(e_err[1]));
        chk("data_b",  32'(data_b),  32'(e_data[1]));
        if (rst || r || w)
            $display("txn %0d: rst=%0b re=%0b ar=%0d we=%0b aw=%0d dw=%02h | a v=%0b d=%02h e=%0b | b v=%0b d=%02h e=%0b",
                     cyc, rst, r, ar, w, aw, dw & 'hff, valid_a, data_a, err_a, valid_b, data_b, err_b);
    endtask

    // Ports are hammered on address 2 while both instances are still clearing.
    task automatic wait_clear(output int ca, output int cb);
        bit drive;
        ca = 0;
        cb = 0;
        for (int i = 0; i < 200 && (busy_a || busy_b); i++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            drive = busy_a;
            step(1'b0, drive, 2, drive, 2, 'h77);
        end
    endtask

    initial begin
        int ca, cb, va, vb;
        bit rr, ww, rs;
        int ar, aw, dw;

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) m_mem[k][i] = 0;

        vecs[0]  = '{0,  0, 1,  7, 'h11, 0, 0,     0, 0, 0,     0};
        vecs[1]  = '{1,  7, 1, 35, 'h3C, 1, 'h11,  0, 0, 0,     0};
        vecs[2]  = '{1,  7, 1,  7, 'h22, 1, 'h22,  0, 1, 'h11,  0};
        vecs[3]  = '{1,  7, 0,  0, 0,    1, 'h22,  0, 1, 'h11,  0};
        vecs[4]  = '{1, 45, 1, 45, 'h99, 1, 0,     1, 1, 'h22,  0};
        vecs[5]  = '{1, 45, 0,  0, 0,    1, 0,     1, 1, 0,     0};
        vecs[6]  = '{0,  0, 0,  0, 0,    0, 0,     0, 1, 'h99,  0};
        vecs[7]  = '{0,  0, 0,  0, 0,    0, 0,     0, 0, 0,     0};
        vecs[8]  = '{1, 35, 0,  0, 0,    1, 'h3C,  0, 0, 0,     0};
        vecs[9]  = '{1, 63, 0,  0, 0,    1, 0,     1, 1, 'h3C,  0};
        vecs[10] = '{1, 39, 0,  0, 0,    1, 0,     0, 1, 0,     0};
        vecs[11] = '{0,  0, 0,  0, 0,    0, 0,     0, 1, 0,     0};
        vecs[12] = '{0,  0, 0,  0, 0,    0, 0,     0, 0, 0,     0};

        #2;
        step(1'b1, 1'b1, 3, 1'b1, 3, 'h55);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0);
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        chk("rst_data_b", 32'(data_b), 32'd0);

        wait_clear(ca, cb);
        chk("clear_len_a", 32'(ca), 32'(DEP_A));
        chk("clear_len_b", 32'(cb), 32'(DEP_B));

        step(1'b0, 1'b1, 2, 1'b0, 0, 0);
        chk("gated_wr_a", 32'(data_a), 32'h00);
        chk("gated_rd_valid_a", 32'(valid_a), 32'd1);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0);
        chk("gated_wr_b", 32'(data_b), 32'h00);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step(1'b0, bit'(vecs[i].re), vecs[i].ar, bit'(vecs[i].we), vecs[i].aw, vecs[i].dw);
            chk($sformatf("vec%0d_valid_a", i), 32'(valid_a), 32'(vecs[i].va));
            chk($sformatf("vec%0d_err_a", i),   32'(err_a),   32'(vecs[i].ea));
            if (vecs[i].va != 0) chk($sformatf("vec%0d_data_a", i), 32'(data_a), 32'(vecs[i].da));
            chk($sformatf("vec%0d_valid_b", i), 32'(valid_b), 32'(vecs[i].vb));
            chk($sformatf("vec%0d_err_b", i),   32'(err_b),   32'(vecs[i].eb));
            if (vecs[i].vb != 0) chk($sformatf("vec%0d_data_b", i), 32'(data_b), 32'(vecs[i].db));
        end

        // Clear after reset, then a reset seven cycles into the clear restarts it.
        step(1'b0, 1'b0, 0, 1'b1, 5, 'hAA);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 5, 1'b1, 5, 'h33);
        chk("midclear_busy_a", 32'(busy_a), 32'd1);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0);
        wait_clear(ca, cb);
        chk("reclear_len_a", 32'(ca), 32'(DEP_A));
        chk("reclear_len_b", 32'(cb), 32'(DEP_B));
        step(1'b0, 1'b1, 5, 1'b0, 0, 0);
        chk("cleared5_valid_a", 32'(valid_a), 32'd1);
        chk("cleared5_data_a",  32'(data_a),  32'h00);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0);
        chk("cleared5_data_b",  32'(data_b),  32'h00);

        // Streaming: 32 writes then 32 back-to-back reads.
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 0, 1'b1, i, i ^ 'h5A);
        va = 0;
        vb = 0;
        for (int i = 0; i < 34; i++) begin
            step(1'b0, bit'(i < 32), (i < 32) ? i : 0, 1'b0, 0, 0);
            va += int'(valid_a);
            vb += int'(valid_b);
        end
        chk("stream_count_a", 32'(va), 32'd32);
        chk("stream_count_b", 32'(vb), 32'd32);

        // Random traffic with occasional resets and forced same-address collisions.
        for (int i = 0; i < 500; i++) begin
            rs = ($urandom_range(0, 149) == 0);
            rr = bit'($urandom_range(0, 1));
            ww = bit'($urandom_range(0, 1));
            ar = int'($urandom_range(0, 63));
            aw = ($urandom_range(0, 3) == 0) ? ar : int'($urandom_range(0, 63));
            dw = int'($urandom_range(0, 255));
            step(rs, rr, ar, ww, aw, dw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sync_param.md
Name: ram_sync_param

Overview:
Parametrised simple-dual-port RAM: one write port, one read port, one clock. Successor to the 2048x8 asynchronous-read buffer used by the string calculator. Adds the following:
- registered read with configurable latency and a valid strobe;
- selectable read-during-write behaviour;
- out-of-range detection;
- a hardware clear sequencer that zeroes the whole array after reset.

Parameters:
DATA_W, 8, bits per location
ADDR_W, 11, address width of both ports
DEPTH, 2048, number of implemented locations; must satisfy 1 <= DEPTH <= 2**ADDR_W
RD_LATENCY, 1, read pipeline depth; legal values 1 or 2
BYPASS, 1, 1 = read-during-write to the same address returns new data; 0 = returns old data
CLEAR_ON_RESET, 1, 1 = zero all locations after reset; 0 = contents untouched by reset

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
busy  output  1  high while the clear sequence runs; both ports are ignored while high
re  input  1  read request, sampled with addr_r
addr_r  input  ADDR_W  read address
data_r  output  DATA_W  read data, qualified by valid_r
valid_r  output  1  one-cycle strobe per accepted read
err_r  output  1  with valid_r: the accepted read was out of range
we  input  1  write enable
addr_w  input  ADDR_W  write address
data_w  input  DATA_W  write data

Behaviour:
- Reset (sampled at edge with reset=1):
  - data_r=0, valid_r=0, err_r=0; all read pipeline stages are cleared.
  - Clear pointer is set to 0.
  - busy=1 if CLEAR_ON_RESET=1, else busy=0.
  - Memory is not modified while reset is held.
- Clear FSM, states IDLE and CLEAR:
  - Reset enters CLEAR when CLEAR_ON_RESET=1, else IDLE.
  - In CLEAR, each edge with reset=0 writes 0 to mem[ptr] and increments ptr.
  - The edge that writes DEPTH-1 moves the FSM to IDLE and sets busy=0.
  - busy is therefore high for exactly DEPTH cycles after reset deasserts.
  - Reset asserted mid-clear restarts the sequence from address 0.
- While busy=1:
  - we and re are ignored: no user write, no read accepted, valid_r stays 0.
- Write:
  - Accepted at an edge where we=1, busy=0 and addr_w < DEPTH: mem[addr_w] <= data_w.
  - A write with addr_w >= DEPTH is dropped silently.
- Read:
  - Accepted at edge N when re=1 and busy=0.
  - data_r, valid_r and err_r update at edge N+RD_LATENCY-1. RD_LATENCY=1 gives outputs visible after the sampling edge; RD_LATENCY=2 adds one more registered stage.
  - valid_r is high for exactly one cycle per accepted read.
  - Back-to-back reads give back-to-back valid_r, one read per cycle at full throughput.
  - data_r holds its last value when valid_r=0.
  - If addr_r >= DEPTH: data_r=0 and err_r=1 with valid_r. Otherwise err_r=0.
- Read-during-write (same edge, we=1, re=1, addr_r==addr_w, address in range):
  - BYPASS=1: returned data = data_w.
  - BYPASS=0: returned data = the prior contents.
  - Different addresses never interact.
- Reset during pending reads: in-flight reads are discarded; no valid_r is produced for them.
- The memory array holds no reset value beyond what the clear sequence writes.

Test Plan:
- Clear after reset: DEPTH=16, CLEAR_ON_RESET=1; preload mem[5]=0xAA, pulse reset one cycle -> busy high exactly 16 cycles; then a read of 5 returns 0x00 with valid_r=1, err_r=0.
- Write/read latency: write 0x3C to 0x123; read 0x123 at edge N -> RD_LATENCY=1 gives data_r=0x3C, valid_r=1 after edge N only; RD_LATENCY=2 gives them after edge N+1; single-cycle valid_r in both cases.
- Read-during-write collision: mem[7]=0x11; same edge we=1/addr_w=7/data_w=0x22 and re=1/addr_r=7 -> BYPASS=1 returns 0x22, BYPASS=0 returns 0x11; a following read returns 0x22 in both.
- Out of range: DEPTH=1000, ADDR_W=10; write 0xFF to 1010 -> dropped; read 1010 -> data_r=0, err_r=1, valid_r=1; read 999 -> err_r=0.
- Reset mid-clear and port gating: assert reset at clear cycle 7 -> busy stays high a further DEPTH cycles from release; we=1 and re=1 during busy -> no write lands, valid_r=0.
- Streaming: write addresses 0..31 with value = addr^0x5A; then 32 consecutive reads -> 32 consecutive valid_r cycles with matching data in order.
